// File: rtl/logic_pipe.sv
// logic_pipe: bitwise logic unit with a running AND accumulator,
// feeding a DEPTH-stage valid/ready pipeline.
module logic_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] dat;
  } stage_t;

  stage_t           stg [DEPTH];
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] result;
  logic [7:0]       op_hot;
  logic             in_xfer;

  // A stage can load if any stage at or after it
  // is empty, or the tail is draining this cycle.
  always_comb begin
    load[DEPTH-1] = !stg[DEPTH-1].vld || out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      load[k] = !stg[k].vld || load[k+1];
    end
  end

  assign in_ready = load[0];
  assign in_xfer  = in_valid && in_ready;
  assign op_hot   = 8'b1 << op;

  always_comb begin
    result  = '0;
    acc_nxt = acc;
    unique case (1'b1)
      op_hot[0]: result = A & B;
      op_hot[1]: result = A | B;
      op_hot[2]: result = A ^ B;
      op_hot[3]: result = ~(A | B);
      op_hot[4]: result = A & ~B;
      op_hot[5]: result = A;
      op_hot[6]: begin
        acc_nxt = acc & A;
        result  = acc & A;
      end
      op_hot[7]: begin
        acc_nxt = '1;
        result  = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '1;
      for (int k = 0; k < DEPTH; k++) begin
        stg[k] <= '0;
      end
    end else begin
      if (in_xfer) begin
        acc <= acc_nxt;
      end
      if (load[0]) begin
        stg[0].vld <= in_xfer;
        if (in_xfer) begin
          stg[0].dat <= result;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) begin
          stg[k].vld <= stg[k-1].vld;
          if (stg[k-1].vld) begin
            stg[k].dat <= stg[k-1].dat;
          end
        end
      end
    end
  end

  assign res       = stg[DEPTH-1].dat;
  assign out_valid = stg[DEPTH-1].vld;
  assign zero      = out_valid && (res == '0);

endmodule

// File: doc/logic_pipe.md
LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of pipeline register stages (legal range 1..4).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, as below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 op  input  3  operation select, decoded per REQ-012.
REQ-009 in_valid / in_ready  input / output  1 each  input handshake.
REQ-010 res  output  WIDTH  result, valid when out_valid=1.
REQ-011 zero, out_valid / out_ready  output, output / input  1 each  zero flag (res==0), and the output handshake.

Function
REQ-012 op decode SHALL be:
- 000 AND: A&B
- 001 OR: A|B
- 010 XOR: A^B
- 011 NOR: ~(A|B)
- 100 ANDN: A&~B
- 101 PASS: A
- 110 ACC_AND: acc<=acc&A, result = new acc
- 111 ACC_CLR: acc<=all-ones, result = all-ones
REQ-013 The result SHALL be computed at the input transfer and carried through DEPTH valid-tagged stages; B is ignored for ops 101/110/111.
REQ-014 An input transfer SHALL occur on any cycle with in_valid=1 and in_ready=1; acc SHALL update only on a transfer with op 110/111.
REQ-015 Back-to-back ACC_AND transfers SHALL chain: each result includes all earlier accepted ACC_AND operands since the last ACC_CLR or reset.
REQ-016 An output transfer SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-017 Stage k SHALL load when it is empty or its contents move on the same cycle; the last stage moves on an output transfer.
REQ-018 in_ready SHALL be combinational: 1 when stage 1 is empty or stage 1 moves this cycle.
REQ-019 With out_ready held at 1, latency SHALL be exactly DEPTH cycles from input transfer to out_valid, at a throughput of one result per cycle.
REQ-020 When full and stalled (out_ready=0), all stage contents, res and out_valid SHALL hold stable.
REQ-021 Results SHALL leave in acceptance order, and none SHALL be dropped or duplicated.
REQ-022 In-flight capacity SHALL be exactly DEPTH; while all stages are valid and out_ready=0, in_ready SHALL be 0.
REQ-023 A simultaneous input and output transfer when full SHALL be accepted, and occupancy SHALL stay DEPTH.
REQ-024 zero SHALL be combinational (out_valid && res==0), i.e. 0 whenever out_valid=0.
REQ-025 res SHALL drive the last-stage data whenever out_valid=1; its value while out_valid=0 is don't-care for checking.

Reset
REQ-026 On rst=1 at a clock edge, all stage valid bits, out_valid and zero SHALL be 0, all stage data and res SHALL be 0, and acc SHALL be all-ones.
REQ-027 Reset SHALL discard in-flight results without producing output; in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-028 in_valid asserted together with rst SHALL NOT cause a transfer or change acc.

Verification
REQ-029 WIDTH=32, DEPTH=2, out_ready=1: A=32'h0000F0AF, B=32'h0000052B, ops 000,001,010 on consecutive cycles -> res 32'h0000002B, 32'h0000F5AF, 32'h0000F584, starting 2 cycles after the first transfer, with out_valid high for 3 consecutive cycles.
REQ-030 op=011 with A=B=0 -> res 32'hFFFFFFFF, zero=0; op=000 with A=32'hF0, B=32'h0F -> res 0, zero=1.
REQ-031 ACC_CLR, then ACC_AND with A=32'hFF00FF00, then ACC_AND with A=32'h0FF00FF0 -> results 32'hFFFFFFFF, 32'hFF00FF00, 32'h0F000F00 in order.
REQ-032 Hold out_ready=0 and offer 3 inputs -> exactly 2 accepted, in_ready=0, res stable; raise out_ready -> both results drain in order, then the third input is accepted.
REQ-033 Assert rst with 2 results in flight -> out_valid=0 next cycle, no stale output ever appears; then ACC_AND with A=32'h1234 -> res 32'h00001234.
REQ-034 DEPTH=1 and DEPTH=4 builds: random op/A/B with random in_valid/out_ready -> scoreboard match, order preserved, latency equal to DEPTH when unstalled.
